spy_port: RTL and testbench

Host-side access controller for the spy bus. It accepts a req/ack four-phase request from the debug host, which carries a 5-bit spy address, a read/write flag and write data. It then drives exactly one spy select (reads) or one load strobe (writes), asserts dbread, captures the 16-bit spy read mux output and returns it to the host. It sits directly upstream of the spy read mux: its select outputs and dbread feed the mux, and the mux output feeds back into spy_in.

---
 rtl/spy_port.sv | 187 ++++++++++++++++++
 tb/tb_spy_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_port.sv
// spy_port: host-side access controller for the spy bus.
// Accepts a four-phase req/ack transaction from the debug host, drives one
// spy read select (with dbread) or one load strobe, captures the spy read
// mux output and returns it to the host. All outputs come straight from flops.
module spy_port #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [4:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   input  logic [15:0] spy_in,
   output logic        dbread,
   output logic        spy_irl, spy_irm, spy_irh, spy_scratch,
   output logic        spy_opc, spy_pc, spy_obl_, spy_obh_,
   output logic        spy_flag1, spy_flag2, spy_ml, spy_mh,
   output logic        spy_al, spy_ah, spy_stl, spy_sth,
   output logic        spy_mdl, spy_mdh, spy_vmal, spy_vmah,
   output logic        spy_obl, spy_obh, spy_disk, spy_bd,
   output logic        ldirl, ldirm, ldirh, ldscratch,
   output logic        ldopc, ldmode, ldclk,
   output logic [15:0] spy_wdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The settle counter counts down to zero, so a SETTLE of N spends N cycles in SEL.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [23:0] sel_q, sel_d;
   logic [6:0]  ld_q, ld_d;
   logic        dbread_q, dbread_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic [15:0] rdata_q, rdata_d;

   // One-hot read select for spy addresses 0-23; unmapped addresses select nothing.
   function automatic logic [23:0] sel_decode(input logic [4:0] a);
      if (a < 5'd24) begin
         sel_decode = 24'd1 << a;
      end else begin
         sel_decode = 24'd0;
      end
   endfunction

   // One-hot load strobe for spy addresses 0-6; other addresses strobe nothing.
   function automatic logic [6:0] ld_decode(input logic [4:0] a);
      if (a < 5'd7) begin
         ld_decode = 7'd1 << a;
      end else begin
         ld_decode = 7'd0;
      end
   endfunction

   // Next-state and next-output computation for the IDLE -> SEL -> DONE handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      sel_d    = sel_q;
      ld_d     = ld_q;
      dbread_d = dbread_q;
      ack_d    = ack_q;
      busy_d   = busy_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            ack_d = 1'b0;
            if (req) begin
               state_d = ST_SEL;
               busy_d  = 1'b1;
               cnt_d   = CNT_INIT;
               wr_d    = wr;
               addr_d  = addr;
               wdata_d = wdata;
               if (wr) begin
                  ld_d     = ld_decode(addr);
                  sel_d    = 24'd0;
                  dbread_d = 1'b0;
               end else begin
                  ld_d     = 7'd0;
                  sel_d    = sel_decode(addr);
                  dbread_d = (addr < 5'd24);
               end
            end else begin
               busy_d   = 1'b0;
               sel_d    = 24'd0;
               ld_d     = 7'd0;
               dbread_d = 1'b0;
            end
         end
         ST_SEL: begin
            if (wr_q) begin
               // Writes take a single SEL cycle whatever SETTLE is.
               ld_d    = 7'd0;
               ack_d   = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q == 4'd0) begin
               sel_d    = 24'd0;
               dbread_d = 1'b0;
               ack_d    = 1'b1;
               state_d  = ST_DONE;
               if (addr_q < 5'd24) begin
                  rdata_d = spy_in;
               end else begin
                  rdata_d = 16'hFFFF;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (!req) begin
               ack_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               ack_d = 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            sel_d    = 24'd0;
            ld_d     = 7'd0;
            dbread_d = 1'b0;
            ack_d    = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         addr_q   <= 5'd0;
         wdata_q  <= 16'd0;
         sel_q    <= 24'd0;
         ld_q     <= 7'd0;
         dbread_q <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         ld_q     <= ld_d;
         dbread_q <= dbread_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         rdata_q  <= rdata_d;
      end
   end

   assign {spy_bd, spy_disk, spy_obh, spy_obl, spy_vmah, spy_vmal, spy_mdh, spy_mdl,
           spy_sth, spy_stl, spy_ah, spy_al, spy_mh, spy_ml, spy_flag2, spy_flag1,
           spy_obh_, spy_obl_, spy_pc, spy_opc, spy_scratch, spy_irh, spy_irm, spy_irl} = sel_q;
   assign {ldclk, ldmode, ldopc, ldscratch, ldirh, ldirm, ldirl} = ld_q;
   assign dbread    = dbread_q;
   assign ack       = ack_q;
   assign busy      = busy_q;
   assign rdata     = rdata_q;
   assign spy_wdata = wdata_q;

endmodule

// File: tb/tb_spy_port.sv
// Directed testbench for spy_port: one instance with SETTLE=1, one with SETTLE=3,
// sharing the host-side stimulus.
module tb_spy_port;

   logic        clk;
   logic        reset;
   logic        req;
   logic        wr;
   logic [4:0]  addr;
   logic [15:0] wdata;
   logic [15:0] spy_in;

   logic [23:0] sel1, sel3;
   logic [6:0]  ld1, ld3;
   logic        db1, db3, ack1, ack3, busy1, busy3;
   logic [15:0] rdata1, rdata3, wd1, wd3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] wdata;
      logic [15:0] spy;
      logic [23:0] sel;
      logic [6:0]  ld;
      logic        db;
      logic [15:0] rdata;
   } vec_t;

   vec_t vecs[11];

   spy_port #(.SETTLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ack(ack1), .busy(busy1), .spy_in(spy_in), .dbread(db1),
      .spy_irl(sel1[0]), .spy_irm(sel1[1]), .spy_irh(sel1[2]), .spy_scratch(sel1[3]),
      .spy_opc(sel1[4]), .spy_pc(sel1[5]), .spy_obl_(sel1[6]), .spy_obh_(sel1[7]),
      .spy_flag1(sel1[8]), .spy_flag2(sel1[9]), .spy_ml(sel1[10]), .spy_mh(sel1[11]),
      .spy_al(sel1[12]), .spy_ah(sel1[13]), .spy_stl(sel1[14]), .spy_sth(sel1[15]),
      .spy_mdl(sel1[16]), .spy_mdh(sel1[17]), .spy_vmal(sel1[18]), .spy_vmah(sel1[19]),
      .spy_obl(sel1[20]), .spy_obh(sel1[21]), .spy_disk(sel1[22]), .spy_bd(sel1[23]),
      .ldirl(ld1[0]), .ldirm(ld1[1]), .ldirh(ld1[2]), .ldscratch(ld1[3]),
      .ldopc(ld1[4]), .ldmode(ld1[5]), .ldclk(ld1[6]),
      .spy_wdata(wd1)
   );

   spy_port #(.SETTLE(3)) u_dut3 (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata3), .ack(ack3), .busy(busy3), .spy_in(spy_in), .dbread(db3),
      .spy_irl(sel3[0]), .spy_irm(sel3[1]), .spy_irh(sel3[2]), .spy_scratch(sel3[3]),
      .spy_opc(sel3[4]), .spy_pc(sel3[5]), .spy_obl_(sel3[6]), .spy_obh_(sel3[7]),
      .spy_flag1(sel3[8]), .spy_flag2(sel3[9]), .spy_ml(sel3[10]), .spy_mh(sel3[11]),
      .spy_al(sel3[12]), .spy_ah(sel3[13]), .spy_stl(sel3[14]), .spy_sth(sel3[15]),
      .spy_mdl(sel3[16]), .spy_mdh(sel3[17]), .spy_vmal(sel3[18]), .spy_vmah(sel3[19]),
      .spy_obl(sel3[20]), .spy_obh(sel3[21]), .spy_disk(sel3[22]), .spy_bd(sel3[23]),
      .ldirl(ld3[0]), .ldirm(ld3[1]), .ldirh(ld3[2]), .ldscratch(ld3[3]),
      .ldopc(ld3[4]), .ldmode(ld3[5]), .ldclk(ld3[6]),
      .spy_wdata(wd3)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      req   = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Directed stimulus and checks.
   initial begin
      reset  = 1'b1;
      req    = 1'b1;
      wr     = 1'b0;
      addr   = 5'd5;
      wdata  = 16'hCAFE;
      spy_in = 16'h1234;

      //          wr    addr    wdata     spy_in    sel           ld     db    rdata
      vecs[0]  = '{1'b0, 5'd5,  16'h0000, 16'h1234, 24'h000020, 7'h00, 1'b1, 16'h1234};
      vecs[1]  = '{1'b0, 5'd0,  16'h1111, 16'h0F0F, 24'h000001, 7'h00, 1'b1, 16'h0F0F};
      vecs[2]  = '{1'b0, 5'd23, 16'h2222, 16'h8001, 24'h800000, 7'h00, 1'b1, 16'h8001};
      vecs[3]  = '{1'b0, 5'd24, 16'h3333, 16'h5A5A, 24'h000000, 7'h00, 1'b0, 16'hFFFF};
      vecs[4]  = '{1'b1, 5'd3,  16'hBEEF, 16'h0000, 24'h000000, 7'h08, 1'b0, 16'hFFFF};
      vecs[5]  = '{1'b1, 5'd6,  16'h1357, 16'h9999, 24'h000000, 7'h40, 1'b0, 16'hFFFF};
      vecs[6]  = '{1'b0, 5'd12, 16'h4444, 16'hC3C3, 24'h001000, 7'h00, 1'b1, 16'hC3C3};
      vecs[7]  = '{1'b1, 5'd7,  16'h5555, 16'h0001, 24'h000000, 7'h00, 1'b0, 16'hC3C3};
      vecs[8]  = '{1'b1, 5'd20, 16'h6666, 16'h0002, 24'h000000, 7'h00, 1'b0, 16'hC3C3};
      vecs[9]  = '{1'b0, 5'd31, 16'h7777, 16'h0003, 24'h000000, 7'h00, 1'b0, 16'hFFFF};
      vecs[10] = '{1'b0, 5'd16, 16'h8888, 16'h7777, 24'h010000, 7'h00, 1'b1, 16'h7777};

      // Reset held 3 cycles with req high: everything stays 0.
      tick(); tick(); tick();
      chk("rst_sel",   32'(sel1),   32'h0);
      chk("rst_ld",    32'(ld1),    32'h0);
      chk("rst_flags", 32'({db1, ack1, busy1}), 32'h0);
      chk("rst_rdata", 32'(rdata1), 32'h0);
      chk("rst_wdata", 32'(wd1),    32'h0);

      // Release: req accepted on the first edge; read addr 5 (pc), SETTLE=1.
      reset = 1'b0;
      tick();
      chk("pc_sel",   32'(sel1), 32'h000020);
      chk("pc_db",    32'(db1),  32'h1);
      chk("pc_busy",  32'(busy1), 32'h1);
      chk("pc_ack0",  32'(ack1), 32'h0);
      chk("pc_wd",    32'(wd1),  32'hCAFE);
      tick();
      chk("pc_ack",   32'(ack1),   32'h1);
      chk("pc_rdata", 32'(rdata1), 32'h1234);
      chk("pc_off",   32'({sel1, db1}), 32'h0);
      tick();
      chk("pc_ack_hold", 32'({ack1, busy1}), 32'h3);
      req = 1'b0;
      tick();
      chk("pc_ack_drop", 32'({ack1, busy1}), 32'h0);

      // Table-driven single transactions on the SETTLE=1 instance.
      for (int i = 0; i < 11; i++) begin
         req    = 1'b1;
         wr     = vecs[i].wr;
         addr   = vecs[i].addr;
         wdata  = vecs[i].wdata;
         spy_in = vecs[i].spy;
         tick();
         chk($sformatf("v%0d_sel", i),  32'(sel1), 32'(vecs[i].sel));
         chk($sformatf("v%0d_ld", i),   32'(ld1),  32'(vecs[i].ld));
         chk($sformatf("v%0d_db", i),   32'(db1),  32'(vecs[i].db));
         chk($sformatf("v%0d_busy", i), 32'({busy1, ack1}), 32'h2);
         chk($sformatf("v%0d_wd", i),   32'(wd1),  32'(vecs[i].wdata));
         // Post-acceptance input changes must be ignored.
         addr  = ~vecs[i].addr;
         wdata = ~vecs[i].wdata;
         wr    = ~vecs[i].wr;
         tick();
         chk($sformatf("v%0d_ack", i),   32'(ack1),   32'h1);
         chk($sformatf("v%0d_rdata", i), 32'(rdata1), 32'(vecs[i].rdata));
         chk($sformatf("v%0d_off", i),   32'({sel1, ld1, db1}), 32'h0);
         chk($sformatf("v%0d_wd2", i),   32'(wd1),    32'(vecs[i].wdata));
         req = 1'b0;
         tick();
         chk($sformatf("v%0d_idle", i), 32'({ack1, busy1}), 32'h0);
      end

      // SETTLE=3 read of addr 16 (mdl); spy_in changes in the 2nd SEL cycle.
      pulse_reset();
      req    = 1'b1;
      wr     = 1'b0;
      addr   = 5'd16;
      wdata  = 16'h0000;
      spy_in = 16'hAAAA;
      tick();
      chk("mdl_sel1", 32'({sel3, db3}), 32'({24'h010000, 1'b1}));
      chk("mdl_ack1", 32'(ack3), 32'h0);
      spy_in = 16'h5555;
      tick();
      chk("mdl_sel2", 32'({sel3, db3}), 32'({24'h010000, 1'b1}));
      chk("mdl_ack2", 32'(ack3), 32'h0);
      tick();
      chk("mdl_sel3", 32'({sel3, db3}), 32'({24'h010000, 1'b1}));
      chk("mdl_ack3", 32'(ack3), 32'h0);
      tick();
      chk("mdl_ack",   32'(ack3),   32'h1);
      chk("mdl_off",   32'({sel3, db3}), 32'h0);
      chk("mdl_rdata", 32'(rdata3), 32'h5555);
      req = 1'b0;
      tick();
      chk("mdl_idle", 32'({ack3, busy3}), 32'h0);

      // SETTLE=3 unmapped read (addr 28), req dropped during SEL: still completes,
      // ack lasts one cycle because req is already low in DONE.
      req    = 1'b1;
      addr   = 5'd28;
      spy_in = 16'h0123;
      tick();
      req = 1'b0;
      chk("un_nosel", 32'({sel3, db3}), 32'h0);
      chk("un_busy",  32'(busy3), 32'h1);
      tick();
      tick();
      chk("un_ack0",  32'(ack3), 32'h0);
      tick();
      chk("un_ack",   32'(ack3),   32'h1);
      chk("un_rdata", 32'(rdata3), 32'hFFFF);
      tick();
      chk("un_ack1cyc", 32'({ack3, busy3}), 32'h0);

      // SETTLE=3 write to addr 4 (ldopc): single SEL cycle regardless of SETTLE.
      req   = 1'b1;
      wr    = 1'b1;
      addr  = 5'd4;
      wdata = 16'hA5A5;
      tick();
      chk("w3_ld",  32'(ld3), 32'h10);
      chk("w3_db",  32'(db3), 32'h0);
      tick();
      chk("w3_ack",   32'(ack3),   32'h1);
      chk("w3_ld0",   32'(ld3),    32'h0);
      chk("w3_rdata", 32'(rdata3), 32'hFFFF);
      chk("w3_wd",    32'(wd3),    32'hA5A5);
      req = 1'b0;
      tick();

      // Reset during SEL of a SETTLE=3 read aborts with no later ack.
      req  = 1'b1;
      wr   = 1'b0;
      addr = 5'd1;
      tick();
      chk("ab_sel", 32'(sel3), 32'h000002);
      reset = 1'b1;
      tick();
      chk("ab_off",   32'({sel3, ld3, db3, ack3, busy3}), 32'h0);
      chk("ab_rdata", 32'(rdata3), 32'h0);
      chk("ab_wd",    32'(wd3),    32'h0);
      req   = 1'b0;
      reset = 1'b0;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk($sformatf("ab_quiet%0d", j), 32'({sel3, db3, ack3, busy3}), 32'h0);
      end

      // Back-to-back read then write on SETTLE=1: one idle edge between them.
      req    = 1'b1;
      wr     = 1'b0;
      addr   = 5'd2;
      spy_in = 16'h4242;
      tick();
      chk("bb_rsel", 32'(sel1), 32'h000004);
      tick();
      chk("bb_rack",   32'(ack1),   32'h1);
      chk("bb_rrdata", 32'(rdata1), 32'h4242);
      req   = 1'b0;
      wr    = 1'b1;
      addr  = 5'd0;
      wdata = 16'h0F1E;
      tick();
      chk("bb_gap", 32'({ld1, ack1, busy1}), 32'h0);
      req = 1'b1;
      tick();
      chk("bb_wld",   32'(ld1),   32'h01);
      chk("bb_wbusy", 32'(busy1), 32'h1);
      chk("bb_wwd",   32'(wd1),   32'h0F1E);
      tick();
      chk("bb_wack",   32'(ack1),   32'h1);
      chk("bb_wrdata", 32'(rdata1), 32'h4242);
      req = 1'b0;
      tick();
      chk("bb_end", 32'({ack1, busy1}), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
